// File: rtl/iteration_variable_counter.sv
// iteration_variable_counter
//   One signed iteration variable of a loop dimension. The value and bound feed an
//   external equality comparator, whose result (i_cmp_eq) reloads the variable and
//   produces a carry pulse for the next-outer dimension (o_carry_out -> i_step_en).
//
//   State | meaning
//   IDLE  | configured or reset, waiting for start
//   RUN   | counting on i_step_en
//   DONE  | last iteration taken (WRAP_MODE=0) or overflow stop
//
//   Optional macro ITER_CNT_OVERFLOW_DET_EN: stop in DONE with a sticky o_overflow when
//   a step would overshoot the bound, overflow the signed add, or use a zero stride.
//   Without it, o_overflow stays 0 and the value wraps silently.
module iteration_variable_counter #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int WRAP_MODE                = 1
) (
  input  logic                                       i_clk,
  input  logic                                       i_reset,
  input  logic                                       i_cfg_load,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] i_cfg_start,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] i_cfg_end,
  input  logic signed [ITERATION_VARIABLE_WIDTH-1:0] i_cfg_stride,
  input  logic                                       i_start,
  input  logic                                       i_step_en,
  input  logic                                       i_cmp_eq,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0] o_iter_value,
  output logic signed [ITERATION_VARIABLE_WIDTH-1:0] o_iter_bound,
  output logic                                       o_last,
  output logic                                       o_carry_out,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic                                       o_overflow
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic signed [W-1:0]   r_iter_value;
  logic signed [W-1:0]   r_iter_bound;
  logic signed [W-1:0]   r_start_q;
  logic signed [W-1:0]   r_stride_q;
  logic                  r_carry;
  logic                  r_overflow;
  logic signed [W-1:0]   w_iter_value_nxt;
  logic signed [W-1:0]   w_iter_bound_nxt;
  logic signed [W-1:0]   w_start_q_nxt;
  logic signed [W-1:0]   w_stride_q_nxt;
  logic                  w_carry_nxt;
  logic                  w_overflow_nxt;
  logic signed [W-1:0]   w_sum;
  logic                  w_stop;

`ifdef ITER_CNT_OVERFLOW_DET_EN
  // One extra bit keeps the true sum so bound comparisons stay exact even when the
  // W-bit add would wrap.
  logic signed [W:0] w_sum_ext;
  logic              w_stride_pos;
  logic              w_stride_neg;
  logic              w_stride_zero;
  logic              w_add_ovf;

  assign w_sum_ext     = {r_iter_value[W-1], r_iter_value} + {r_stride_q[W-1], r_stride_q};
  assign w_sum         = w_sum_ext[W-1:0];
  assign w_stride_neg  = r_stride_q[W-1];
  assign w_stride_zero = ~|r_stride_q;
  assign w_stride_pos  = !w_stride_neg && !w_stride_zero;
  assign w_add_ovf     = w_sum_ext[W] != w_sum_ext[W-1];
  assign w_stop        = w_add_ovf
                      || (w_stride_pos && (w_sum_ext > r_iter_bound))
                      || (w_stride_neg && (w_sum_ext < r_iter_bound))
                      || w_stride_zero;
`else
  assign w_sum  = r_iter_value + r_stride_q;
  assign w_stop = 1'b0;
`endif

  // Next-state and next-register values; everything holds unless a rule fires.
  always_comb begin
    w_state_nxt      = r_state;
    w_iter_value_nxt = r_iter_value;
    w_iter_bound_nxt = r_iter_bound;
    w_start_q_nxt    = r_start_q;
    w_stride_q_nxt   = r_stride_q;
    w_carry_nxt      = 1'b0;
    w_overflow_nxt   = r_overflow;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_cfg_load) begin
          w_start_q_nxt    = i_cfg_start;
          w_iter_bound_nxt = i_cfg_end;
          w_stride_q_nxt   = i_cfg_stride;
          w_iter_value_nxt = i_cfg_start;
          w_overflow_nxt   = 1'b0;
          w_state_nxt      = S_IDLE;
        end else if (i_start) begin
          w_iter_value_nxt = r_start_q;
          w_overflow_nxt   = 1'b0;
          w_state_nxt      = S_RUN;
        end
      end
      S_RUN: begin
        if (i_step_en) begin
          if (i_cmp_eq) begin
            w_carry_nxt      = 1'b1;
            w_iter_value_nxt = r_start_q;
            if (WRAP_MODE == 0) begin
              w_state_nxt = S_DONE;
            end
          end else if (w_stop) begin
            w_overflow_nxt = 1'b1;
            w_state_nxt    = S_DONE;
          end else begin
            w_iter_value_nxt = w_sum;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_iter_value <= '0;
      r_iter_bound <= '0;
      r_start_q    <= '0;
      r_stride_q   <= '0;
      r_carry      <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_iter_value <= w_iter_value_nxt;
      r_iter_bound <= w_iter_bound_nxt;
      r_start_q    <= w_start_q_nxt;
      r_stride_q   <= w_stride_q_nxt;
      r_carry      <= w_carry_nxt;
      r_overflow   <= w_overflow_nxt;
    end
  end

  assign o_iter_value = r_iter_value;
  assign o_iter_bound = r_iter_bound;
  assign o_last       = (r_state == S_RUN) && i_cmp_eq;
  assign o_carry_out  = r_carry;
  assign o_busy       = (r_state == S_RUN);
  assign o_done       = (r_state == S_DONE);
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_iteration_variable_counter.sv
// Bench for iteration_variable_counter: two instances (WRAP_MODE 0 and 1) share the
// same stimulus; each has its own equality comparator and is compared every cycle
// against an integer-arithmetic reference of the loop behaviour.
module tb_iteration_variable_counter;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                b_reset = 1'b1;
  logic                b_load  = 1'b0;
  logic                b_start = 1'b0;
  logic                b_step  = 1'b0;
  logic signed [W-1:0] b_cs    = '0;
  logic signed [W-1:0] b_ce    = '0;
  logic signed [W-1:0] b_cst   = '0;

  logic signed [W-1:0] w_val [2];
  logic signed [W-1:0] w_bnd [2];
  logic                w_eq  [2];
  logic                w_last[2];
  logic                w_cry [2];
  logic                w_busy[2];
  logic                w_done[2];
  logic                w_ovf [2];
  logic [36:0]         w_obs [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign w_eq[g]  = (w_val[g] == w_bnd[g]);
    assign w_obs[g] = {w_val[g], w_bnd[g], w_last[g], w_cry[g], w_busy[g], w_done[g], w_ovf[g]};
    iteration_variable_counter #(.ITERATION_VARIABLE_WIDTH(W), .WRAP_MODE(g)) u_dut (
      .i_clk       (clk),
      .i_reset     (b_reset),
      .i_cfg_load  (b_load),
      .i_cfg_start (b_cs),
      .i_cfg_end   (b_ce),
      .i_cfg_stride(b_cst),
      .i_start     (b_start),
      .i_step_en   (b_step),
      .i_cmp_eq    (w_eq[g]),
      .o_iter_value(w_val[g]),
      .o_iter_bound(w_bnd[g]),
      .o_last      (w_last[g]),
      .o_carry_out (w_cry[g]),
      .o_busy      (w_busy[g]),
      .o_done      (w_done[g]),
      .o_overflow  (w_ovf[g])
    );
  end

  // Reference: mode 0 idle, 1 running, 2 finished; values held as plain integers.
  int m_mode[2], m_val[2], m_bound[2], m_first[2], m_stride[2], m_carry[2], m_ovf[2];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int wrap16(input int x);
    logic signed [W-1:0] t;
    t = x[W-1:0];
    return int'(t);
  endfunction

  function automatic logic [36:0] f_exp(input int k);
    logic signed [W-1:0] v, b;
    v = W'(m_val[k]);
    b = W'(m_bound[k]);
    return {v, b, (m_mode[k] == 1) && (m_val[k] == m_bound[k]), m_carry[k] != 0,
            m_mode[k] == 1, m_mode[k] == 2, m_ovf[k] != 0};
  endfunction

  task automatic model_update();
    int sum;
    bit stop;
    for (int k = 0; k < 2; k++) begin
      m_carry[k] = 0;
      if (b_reset) begin
        m_mode[k] = 0; m_val[k] = 0; m_bound[k] = 0; m_first[k] = 0; m_stride[k] = 0; m_ovf[k] = 0;
      end else if (m_mode[k] != 1) begin
        if (b_load) begin
          m_first[k] = int'(b_cs); m_bound[k] = int'(b_ce); m_stride[k] = int'(b_cst);
          m_val[k] = int'(b_cs); m_ovf[k] = 0; m_mode[k] = 0;
        end else if (b_start) begin
          m_val[k] = m_first[k]; m_ovf[k] = 0; m_mode[k] = 1;
        end
      end else if (b_step) begin
        if (m_val[k] == m_bound[k]) begin
          m_carry[k] = 1;
          m_val[k] = m_first[k];
          if (k == 0) m_mode[k] = 2;
        end else begin
          sum = m_val[k] + m_stride[k];
`ifdef ITER_CNT_OVERFLOW_DET_EN
          stop = (sum > 32767) || (sum < -32768) || (m_stride[k] == 0)
              || (m_stride[k] > 0 && sum > m_bound[k]) || (m_stride[k] < 0 && sum < m_bound[k]);
`else
          stop = 1'b0;
`endif
          if (stop) begin
            m_ovf[k] = 1; m_mode[k] = 2;
          end else begin
            m_val[k] = wrap16(sum);
          end
        end
      end
    end
  endtask

  // One clock: DUT and reference both take the inputs present at this edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_in(input bit rst, input bit ld, input bit st, input bit sp);
    b_reset = rst; b_load = ld; b_start = st; b_step = sp;
  endtask

  task automatic set_cfg(input int s, input int e, input int d);
    b_cs = W'(s); b_ce = W'(e); b_cst = W'(d);
  endtask

  task automatic test_reset();
    set_in(1, 0, 0, 0);
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (w_obs[k] !== 37'd0) begin
        n_err++; $display("FAIL reset_state[%0d]: got %h, want 0", k, w_obs[k]);
      end
    end
    set_cfg(2, 9, 1);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL reset_pre[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
    set_in(1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== 37'd0) begin
          n_err++; $display("FAIL reset_midrun[%0d] cyc %0d: got %h, want 0", k, i, w_obs[k]);
        end
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_up_count();
    int exp_v[5] = '{1, 2, 3, 0, 0};
    set_cfg(0, 3, 1);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (int'(w_val[0]) != exp_v[i] || w_cry[0] !== (i == 3)) begin
        n_err++;
        $display("FAIL up_count_seq cyc %0d: got val %0d carry %0b, want val %0d carry %0b",
                 i, w_val[0], w_cry[0], exp_v[i], i == 3);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL up_count[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
    n_cmp++;
    if (w_done[0] !== 1'b1 || w_busy[0] !== 1'b0) begin
      n_err++; $display("FAIL up_count_done: got done %0b busy %0b, want 1 0", w_done[0], w_busy[0]);
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_down_wrap();
    int exp_v[8] = '{3, 1, -1, 5, 3, 1, -1, 5};
    set_in(1, 0, 0, 0); tick();
    set_cfg(5, -1, -2);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (int'(w_val[1]) != exp_v[i] || w_cry[1] !== (i == 3 || i == 7) || w_busy[1] !== 1'b1) begin
        n_err++;
        $display("FAIL down_wrap_seq cyc %0d: got val %0d carry %0b busy %0b, want val %0d carry %0b busy 1",
                 i, w_val[1], w_cry[1], w_busy[1], exp_v[i], i == 3 || i == 7);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL down_wrap[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_single_iter();
    set_in(1, 0, 0, 0); tick();
    set_cfg(7, 7, 1);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    n_cmp++;
    if (w_last[0] !== 1'b1 || w_last[1] !== 1'b1) begin
      n_err++; $display("FAIL single_last: got %0b %0b, want 1 1", w_last[0], w_last[1]);
    end
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (w_cry[1] !== 1'b1 || int'(w_val[1]) != 7) begin
        n_err++; $display("FAIL single_step cyc %0d: got carry %0b val %0d, want 1 7", i, w_cry[1], w_val[1]);
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL single_iter[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_priority();
    set_in(1, 0, 0, 0); tick();
    set_cfg(1, 4, 1);
    set_in(0, 1, 1, 0); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (w_busy[k] !== 1'b0 || int'(w_bnd[k]) != 4 || int'(w_val[k]) != 1) begin
        n_err++; $display("FAIL prio_load_start[%0d]: got busy %0b bnd %0d val %0d, want 0 4 1",
                          k, w_busy[k], w_bnd[k], w_val[k]);
      end
    end
    set_in(0, 0, 1, 0); tick();
    set_cfg(9, 9, 9);
    set_in(0, 1, 1, 0); tick();
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (w_obs[k] !== f_exp(k) || int'(w_bnd[k]) != 4 || w_busy[k] !== 1'b1) begin
        n_err++; $display("FAIL prio_load_in_run[%0d]: got %h, want %h (bound 4, busy)", k, w_obs[k], f_exp(k));
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_overshoot();
    set_in(1, 0, 0, 0); tick();
    set_cfg(0, 5, 2);
    set_in(0, 1, 0, 0); tick();
    set_in(0, 0, 1, 0); tick();
    set_in(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL overshoot[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
`ifdef ITER_CNT_OVERFLOW_DET_EN
    n_cmp++;
    if (w_ovf[1] !== 1'b1 || w_done[1] !== 1'b1 || int'(w_val[1]) != 4 || w_cry[1] !== 1'b0) begin
      n_err++; $display("FAIL overshoot_stop: got ovf %0b done %0b val %0d carry %0b, want 1 1 4 0",
                        w_ovf[1], w_done[1], w_val[1], w_cry[1]);
    end
`else
    n_cmp++;
    if (w_ovf[1] !== 1'b0 || w_busy[1] !== 1'b1 || int'(w_val[1]) != 10 || w_cry[1] !== 1'b0) begin
      n_err++; $display("FAIL overshoot_wrap: got ovf %0b busy %0b val %0d carry %0b, want 0 1 10 0",
                        w_ovf[1], w_busy[1], w_val[1], w_cry[1]);
    end
`endif
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      b_reset = ($urandom_range(0, 63) == 0);
      b_load  = ($urandom_range(0, 7) == 0);
      b_start = ($urandom_range(0, 7) == 0);
      b_step  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        b_cs  = W'(32760 - int'($urandom_range(0, 8)));
        b_ce  = W'(int'($urandom_range(0, 8)) - 32768);
        b_cst = W'(int'($urandom_range(0, 6)) - 3);
      end else begin
        b_cs  = W'(int'($urandom_range(0, 16)) - 8);
        b_ce  = W'(int'($urandom_range(0, 16)) - 8);
        b_cst = W'(int'($urandom_range(0, 6)) - 3);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (w_obs[k] !== f_exp(k)) begin
          n_err++; $display("FAIL random[%0d] cyc %0d: got %h, want %h", k, i, w_obs[k], f_exp(k));
        end
      end
    end
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_val[k] = 0; m_bound[k] = 0; m_first[k] = 0;
      m_stride[k] = 0; m_carry[k] = 0; m_ovf[k] = 0;
    end
    test_reset();
    test_up_count();
    test_down_wrap();
    test_single_iter();
    test_priority();
    test_overshoot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
